// File: rtl/dht_sensor_emulator.sv
// DHT11-style sensor responder: detects the MCU start pulse, answers with the
// response handshake, 40 data bits and EOT. Optional macro: CHECKSUM_ERR_INJ_EN.
module dht_sensor_emulator #(
  parameter int CNT_W       = 21,
  parameter int T_START_MIN = 1_800_000,
  parameter int T_WAIT      = 2500,
  parameter int T_RESP_LOW  = 8000,
  parameter int T_RESP_HIGH = 8000,
  parameter int T_BIT_LOW   = 5000,
  parameter int T_ZERO_HIGH = 2650,
  parameter int T_ONE_HIGH  = 7000,
  parameter int T_EOT_LOW   = 5000,
  parameter int T_EOT_HIGH  = 8000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht_i,
  output logic       dht_pull_low_o,
  input  logic [7:0] hum_int_i,
  input  logic [7:0] hum_dec_i,
  input  logic [7:0] temp_int_i,
  input  logic [7:0] temp_dec_i,
`ifdef CHECKSUM_ERR_INJ_EN
  input  logic       chk_corrupt_i,
`endif
  output logic       busy_o,
  output logic       frame_done_o,
  output logic [5:0] bit_idx_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_MEAS_LOW, S_RESP_WAIT, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_EOT_LOW, S_EOT_HIGH
  } state_t;

  localparam logic [CNT_W-1:0] L_START = CNT_W'(T_START_MIN);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

  logic [1:0]       r_sync;
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_limit;
  logic [39:0]      r_sr, w_sr_nx;
  logic [5:0]       r_bit_idx, w_bit_idx_nx;
  logic             r_pull, w_pull_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic             w_s, w_end;
  logic [7:0]       w_chk, w_chk_tx;

  assign w_s   = r_sync[1];
  assign w_chk = hum_int_i + hum_dec_i + temp_int_i + temp_dec_i;
`ifdef CHECKSUM_ERR_INJ_EN
  assign w_chk_tx = chk_corrupt_i ? ~w_chk : w_chk;
`else
  assign w_chk_tx = w_chk;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync    <= 2'b11;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_bit_idx <= '0;
      r_pull    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], dht_i};
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_sr      <= w_sr_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_pull    <= w_pull_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
    end
  end

  // Timed states start with cnt=1 and leave when cnt reaches their limit.
  always_comb begin
    w_limit = '0;
    case (r_state)
      S_RESP_WAIT: w_limit = CNT_W'(T_WAIT);
      S_RESP_LOW:  w_limit = CNT_W'(T_RESP_LOW);
      S_RESP_HIGH: w_limit = CNT_W'(T_RESP_HIGH);
      S_BIT_LOW:   w_limit = CNT_W'(T_BIT_LOW);
      S_BIT_HIGH:  w_limit = r_sr[39] ? CNT_W'(T_ONE_HIGH) : CNT_W'(T_ZERO_HIGH);
      S_EOT_LOW:   w_limit = CNT_W'(T_EOT_LOW);
      S_EOT_HIGH:  w_limit = CNT_W'(T_EOT_HIGH);
      default:     w_limit = '0;
    endcase
  end

  assign w_end = (r_cnt == w_limit);

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt + L_ONE;
    w_sr_nx      = r_sr;
    w_bit_idx_nx = r_bit_idx;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (!w_s) begin
          w_state_nx = S_MEAS_LOW;
          w_cnt_nx   = L_ONE;
        end
      end
      S_MEAS_LOW: begin
        if (!w_s) begin
          w_cnt_nx = (r_cnt == '1) ? r_cnt : r_cnt + L_ONE;
        end else if (r_cnt >= L_START) begin
          w_sr_nx    = {hum_int_i, hum_dec_i, temp_int_i, temp_dec_i, w_chk_tx};
          w_busy_nx  = 1'b1;
          w_state_nx = S_RESP_WAIT;
          w_cnt_nx   = L_ONE;
        end else begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end
      end
      S_RESP_WAIT: if (w_end) begin w_state_nx = S_RESP_LOW;  w_cnt_nx = L_ONE; end
      S_RESP_LOW:  if (w_end) begin w_state_nx = S_RESP_HIGH; w_cnt_nx = L_ONE; end
      S_RESP_HIGH: if (w_end) begin w_state_nx = S_BIT_LOW;   w_cnt_nx = L_ONE; end
      S_BIT_LOW:   if (w_end) begin w_state_nx = S_BIT_HIGH;  w_cnt_nx = L_ONE; end
      S_BIT_HIGH: begin
        if (w_end) begin
          w_cnt_nx = L_ONE;
          w_sr_nx  = {r_sr[38:0], 1'b0};
          if (r_bit_idx == 6'd39) begin
            w_state_nx   = S_EOT_LOW;
            w_bit_idx_nx = '0;
          end else begin
            w_state_nx   = S_BIT_LOW;
            w_bit_idx_nx = r_bit_idx + 6'd1;
          end
        end
      end
      S_EOT_LOW:   if (w_end) begin w_state_nx = S_EOT_HIGH;  w_cnt_nx = L_ONE; end
      S_EOT_HIGH: begin
        if (w_end) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
    w_pull_nx = (w_state_nx == S_RESP_LOW) || (w_state_nx == S_BIT_LOW) ||
                (w_state_nx == S_EOT_LOW);
  end

  assign dht_pull_low_o = r_pull;
  assign busy_o         = r_busy;
  assign frame_done_o   = r_done;
  assign bit_idx_o      = r_bit_idx;

endmodule
